// File: rtl/nor_reduce_seq.sv
// nor_reduce_seq: sequential N-input AND/OR/NAND/NOR reduction built only from 2-input NOR gates
module nor_reduce_seq #(
  parameter int N = 8,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  in,
  output logic          busy,
  output logic          done,
  output logic          out,
  output logic [CW-1:0] count
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] in_r, in_n;
  logic [1:0] mode_r, mode_n;
  logic acc, acc_n, fold, out_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] count_n;
  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction
  function automatic logic not1(input logic x);
    return nor2(x, x);
  endfunction
  function automatic logic or2(input logic x, input logic y);
    return not1(nor2(x, y));
  endfunction
  function automatic logic and2(input logic x, input logic y);
    return nor2(not1(x), not1(y));
  endfunction
  function automatic logic base(input logic a, input logic b, input logic or_type);
    return or_type ? or2(a, b) : and2(a, b);
  endfunction
  function automatic logic fin(input logic a, input logic inv);
    return inv ? not1(a) : a;
  endfunction
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fold = base(acc, in_r[idx], mode_r[0]);
  // dominant value equals mode[0]: 0 for AND-type, 1 for OR-type
  always_comb begin
    state_n = state;
    in_n = in_r;
    mode_n = mode_r;
    acc_n = acc;
    idx_n = idx;
    out_n = out;
    count_n = count;
    if (state == IDLE && start) begin
      in_n = in;
      mode_n = mode;
      acc_n = in[0];
      idx_n = IW'(1);
      state_n = (EARLY_EXIT && in[0] == mode[0]) ? DONE : RUN;
      out_n = (EARLY_EXIT && in[0] == mode[0]) ? fin(in[0], mode[1]) : out;
      count_n = (EARLY_EXIT && in[0] == mode[0]) ? CW'(1) : count;
    end else if (state == RUN) begin
      acc_n = fold;
      idx_n = idx + IW'(1);
      if (idx == IW'(N - 1) || (EARLY_EXIT && fold == mode_r[0])) begin
        state_n = DONE;
        out_n = fin(fold, mode_r[1]);
        count_n = CW'(idx) + CW'(1);
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_r <= '0;
      mode_r <= '0;
      acc <= 1'b0;
      idx <= '0;
      out <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      in_r <= in_n;
      mode_r <= mode_n;
      acc <= acc_n;
      idx <= idx_n;
      out <= out_n;
      count <= count_n;
    end
  end
endmodule

// File: tb/tb_nor_reduce_seq.sv
// tb_nor_reduce_seq: scoreboard bench over three configurations (N=8, N=8 early exit, N=3)
module tb_nor_reduce_seq;
  typedef struct {logic o; int c; int t;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a[3];
  logic [1:0] mode_a[3];
  logic [7:0] in_a[3];
  logic busy_a[3], done_a[3], out_a[3];
  logic [3:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q[3][$];

  nor_reduce_seq #(.N(8), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mode(mode_a[0]), .in(in_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .out(out_a[0]), .count(cnt0));
  nor_reduce_seq #(.N(8), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mode(mode_a[1]), .in(in_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .out(out_a[1]), .count(cnt1));
  nor_reduce_seq #(.N(3), .EARLY_EXIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .mode(mode_a[2]), .in(in_a[2][2:0]),
    .busy(busy_a[2]), .done(done_a[2]), .out(out_a[2]), .count(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cnt_of(input int d);
    return d == 0 ? int'(cnt0) : d == 1 ? int'(cnt1) : int'(cnt2);
  endfunction

  // Reference: result is the dominant value if any bit carries it; early exit stops at its first occurrence
  function automatic exp_t model(input int d, input logic [1:0] m, input logic [7:0] v);
    exp_t e;
    int n = d == 2 ? 3 : 8;
    bit hit = 1'b0;
    e.c = n;
    for (int i = 0; i < n; i++)
      if (v[i] == m[0] && !hit) begin
        hit = 1'b1;
        if (d == 1) e.c = i + 1;
      end
    e.o = (hit ? m[0] : ~m[0]) ^ m[1];
    e.t = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request, then hammer start/in/mode with garbage while busy
  task automatic go(input int d, input logic [1:0] m, input logic [7:0] v);
    exp_t e;
    int k = 0;
    @(negedge clk);
    start_a[d] = 1'b1;
    mode_a[d] = m;
    in_a[d] = v;
    @(posedge clk);
    #1;
    e = model(d, m, v);
    e.t = cyc + e.c - 1;
    q[d].push_back(e);
    forever begin
      @(negedge clk);
      if (!busy_a[d] || k == 40) break;
      start_a[d] = 1'($urandom);
      in_a[d] = 8'($urandom);
      mode_a[d] = 2'($urandom);
      k++;
    end
    start_a[d] = 1'b0;
    check($sformatf("busy_timeout%0d", d), k == 40 ? 1 : 0, 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 3; d++)
      if (done_a[d]) begin
        check($sformatf("done_busy%0d", d), int'(busy_a[d]), 1);
        if (q[d].size() == 0) check($sformatf("spurious_done%0d", d), int'(done_a[d]), 0);
        else begin
          e = q[d].pop_front();
          check($sformatf("out%0d", d), int'(out_a[d]), int'(e.o));
          check($sformatf("count%0d", d), cnt_of(d), e.c);
          check($sformatf("done_cycle%0d", d), cyc, e.t);
        end
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0;
      mode_a[d] = 2'b00;
      in_a[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_busy%0d", d), int'(busy_a[d]), 0);
      check($sformatf("rst_done%0d", d), int'(done_a[d]), 0);
      check($sformatf("rst_out%0d", d), int'(out_a[d]), 0);
      check($sformatf("rst_count%0d", d), cnt_of(d), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    go(0, 2'b00, 8'hFF);
    go(0, 2'b11, 8'h00);
    go(0, 2'b10, 8'hA5);
    go(0, 2'b10, 8'hFF);
    go(0, 2'b01, 8'h00);
    go(1, 2'b00, 8'hFE);
    go(1, 2'b01, 8'h10);
    go(2, 2'b00, 8'h02);
    go(2, 2'b00, 8'h07);
    go(2, 2'b00, 8'h05);
    repeat (20) go(0, 2'($urandom), 8'($urandom));
    repeat (20) go(1, 2'($urandom), 8'($urandom));
    repeat (10) go(2, 2'($urandom), 8'($urandom));
    go(0, 2'b00, 8'hFF);
    @(negedge clk);
    start_a[0] = 1'b1;
    mode_a[0] = 2'b00;
    in_a[0] = 8'hFF;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_out", int'(out_a[0]), 1);
    check("pre_rst_busy", int'(busy_a[0]), 1);
    rst = 1'b1;
    #1;
    check("async_busy", int'(busy_a[0]), 0);
    check("async_done", int'(done_a[0]), 0);
    check("async_out", int'(out_a[0]), 0);
    check("async_count", cnt_of(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    check("post_rst_idle", int'(busy_a[0]), 0);
    go(0, 2'b01, 8'h01);
    repeat (2) @(posedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("queue_empty%0d", d), q[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
